seq_div: RTL and testbench

Sequential restoring divider: the inverse of the team's shift-and-add multiplier (`seq_mul`). It accepts an unsigned N-bit dividend and divisor on a start pulse. It produces an N-bit quotient and N-bit remainder, one restoring shift-subtract step per clock. The block sits beside `seq_mul` in the arithmetic datapath and uses the same start/operand-capture style. It adds a `busy`/`done` handshake so a controller can sequence it.

---
 rtl/seq_div.sv | 162 ++++++++++++++++
 tb/tb_seq_div.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one shift-subtract step per clock.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous reset, active low
//   start  - division request, accepted only while idle
//   a, b   - dividend / divisor (N bits), captured on the accept edge
//   quo    - quotient (registered, held until next completion)
//   rem    - remainder (registered, held until next completion)
//   busy   - division in progress
//   done   - one-cycle pulse when quo/rem update
//   dz     - divide-by-zero flag, valid with done
//
// Build option: define SEQ_DIV_DZ_EN to short-circuit b==0 into a one-cycle
// completion with dz=1. Without it, b==0 runs all N steps and dz is always 0.
module seq_div #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] quo,
    output logic [N-1:0] rem,
    output logic         busy,
    output logic         done,
    output logic         dz
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  q_q, q_d;
    logic [N:0]    r_q, r_d;       // one guard bit so R-D fits without overflow
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          done_q, done_d;
`ifdef SEQ_DIV_DZ_EN
    logic          dzp_q, dzp_d;   // divisor was zero at accept
    logic          dz_q, dz_d;
`endif

    logic [N:0]    sh_r, t, step_r;
    logic [N-1:0]  sh_q, step_q;

    always_comb begin
        // one restoring step on the current {R,Q}
        sh_r = {r_q[N-1:0], q_q[N-1]};
        sh_q = {q_q[N-2:0], 1'b0};
        t    = sh_r - {1'b0, d_q};
        if (t[N]) begin
            step_r = sh_r;
            step_q = sh_q;
        end else begin
            step_r = t;
            step_q = sh_q | N'(1);
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        q_d     = q_q;
        r_d     = r_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
`ifdef SEQ_DIV_DZ_EN
        dzp_d   = dzp_q;
        dz_d    = dz_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = b;
                    q_d     = a;
                    r_d     = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SEQ_DIV_DZ_EN
                    dzp_d   = (b == '0);
`endif
                end
            end
            RUN: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + CW'(1);
`ifdef SEQ_DIV_DZ_EN
                if (dzp_q) begin
                    // Q still holds the untouched dividend on the first step
                    quo_d   = '1;
                    rem_d   = q_q;
                    dz_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    quo_d   = step_q;
                    rem_d   = step_r[N-1:0];
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`else
                if (cnt_q == LAST) begin
                    quo_d   = step_q;
                    rem_d   = step_r[N-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_q     <= '0;
            q_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
`ifdef SEQ_DIV_DZ_EN
            dzp_q   <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            q_q     <= q_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
`ifdef SEQ_DIV_DZ_EN
            dzp_q   <= dzp_d;
            dz_q    <= dz_d;
`endif
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign done = done_q;
    assign busy = (state_q == RUN);
`ifdef SEQ_DIV_DZ_EN
    assign dz   = dz_q;
`else
    assign dz   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed self-checking bench for seq_div (N=4 and N=8 instances).
module tb_seq_div;
    logic       clk;
    logic       reset;
    logic       start, start8;
    logic [3:0] a, b;
    logic [7:0] a8, b8;
    logic [3:0] quo, rem;
    logic [7:0] quo8, rem8;
    logic       busy, done, dz, busy8, done8, dz8;

    int checks = 0;
    int errors = 0;

    seq_div #(.N(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .quo(quo), .rem(rem), .busy(busy), .done(done), .dz(dz)
    );

    seq_div #(.N(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .quo(quo8), .rem(rem8), .busy(busy8), .done(done8), .dz(dz8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ea, eb;
        reset = 1'b0; start = 1'b0; start8 = 1'b0;
        a = '0; b = '0; a8 = '0; b8 = '0;
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_quo",  32'(quo), 0);
        chk("rst_rem",  32'(rem), 0);
        chk("rst_dz",   32'(dz), 0);
        #20 reset = 1'b1;
        tick();

        // 13 / 3 -> 4 r 1
        a = 4'd13; b = 4'd3; start = 1'b1;
        tick();                                   // T0
        start = 1'b0; a = 4'd0; b = 4'd0;
        chk("t1_busy_T0", 32'(busy), 1);
        repeat (3) begin
            tick();
            chk("t1_busy_run", 32'(busy), 1);
            chk("t1_done_run", 32'(done), 0);
        end
        tick();                                   // T4
        chk("t1_done", 32'(done), 1);
        chk("t1_quo",  32'(quo), 4);
        chk("t1_rem",  32'(rem), 1);
        chk("t1_dz",   32'(dz), 0);
        chk("t1_busy_T4", 32'(busy), 0);
        tick();
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_quo_hold", 32'(quo), 4);

        // back-to-back sweep, restarting while done is high
        a = 4'd0; b = 4'd1; start = 1'b1;
        tick();
        for (int k = 0; k < 240; k++) begin
            ea = k / 15; eb = k % 15 + 1;
            start = 1'b0;
            chk("sw_busy", 32'(busy), 1);
            chk("sw_done_lo", 32'(done), 0);
            repeat (3) tick();
            tick();
            chk("sw_done", 32'(done), 1);
            chk("sw_quo", 32'(quo), 32'(ea / eb));
            chk("sw_rem", 32'(rem), 32'(ea % eb));
            if (k < 239) begin
                a = 4'((k + 1) / 15); b = 4'((k + 1) % 15 + 1); start = 1'b1;
                tick();
            end
        end
        tick();
        chk("sw_end_busy", 32'(busy), 0);

        // divide by zero, 9 / 0
        a = 4'd9; b = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dz_busy_T0", 32'(busy), 1);
`ifdef SEQ_DIV_DZ_EN
        tick();                                   // T1
        chk("dz_done", 32'(done), 1);
        chk("dz_flag", 32'(dz), 1);
        chk("dz_busy", 32'(busy), 0);
`else
        repeat (3) begin
            tick();
            chk("dz_done_lo", 32'(done), 0);
        end
        tick();                                   // T4
        chk("dz_done", 32'(done), 1);
        chk("dz_flag", 32'(dz), 0);
`endif
        chk("dz_quo", 32'(quo), 15);
        chk("dz_rem", 32'(rem), 9);
        tick();

        // start during RUN is ignored
        a = 4'd2; b = 4'd7; start = 1'b1;
        tick();                                   // T0
        start = 1'b0;
        tick();                                   // T1
        a = 4'd15; b = 4'd1; start = 1'b1;
        tick();                                   // T2
        start = 1'b0;
        tick();                                   // T3
        tick();                                   // T4
        chk("ig_done", 32'(done), 1);
        chk("ig_quo",  32'(quo), 0);
        chk("ig_rem",  32'(rem), 2);
        repeat (6) begin
            tick();
            chk("ig_no_done", 32'(done), 0);
            chk("ig_no_busy", 32'(busy), 0);
        end
        chk("ig_quo_hold", 32'(quo), 0);

        // reset mid-division
        a = 4'd15; b = 4'd2; start = 1'b1;
        tick();                                   // T0
        start = 1'b0;
        tick(); tick();                           // T1, T2
        #2 reset = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_quo",  32'(quo), 0);
        chk("mr_rem",  32'(rem), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            tick();
            chk("mr_no_done", 32'(done), 0);
        end
        a = 4'd15; b = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        tick();
        chk("mr2_done", 32'(done), 1);
        chk("mr2_quo",  32'(quo), 7);
        chk("mr2_rem",  32'(rem), 1);

        // N=8: 255 / 16 -> 15 r 15
        a8 = 8'd255; b8 = 8'd16; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (7) begin
            tick();
            chk("n8_done_lo", 32'(done8), 0);
            chk("n8_busy", 32'(busy8), 1);
        end
        tick();                                   // T8
        chk("n8_done", 32'(done8), 1);
        chk("n8_quo",  32'(quo8), 15);
        chk("n8_rem",  32'(rem8), 15);
        chk("n8_dz",   32'(dz8), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
